// File: rtl/mem_pkg.sv
// Shared definitions for the mem_resp word-addressed responder: data width,
// default geometry/latency, FSM state encodings and the latched request record.
package mem_pkg;
   localparam int DATA_W          = 32;
   localparam int DEPTH_DEF       = 256;
   localparam int WAIT_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic              we;
      logic [31:0]       addr;
      logic [DATA_W-1:0] wdata;
      logic [3:0]        be;
   } req_t;
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module mem_array
   import mem_pkg::*;
#(
   parameter  int DEPTH = DEPTH_DEF,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are deliberately never reset; rdata only moves on reads.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end
endmodule

// File: rtl/mem_resp.sv
// Memory responder: accepts one request in IDLE, waits WAIT_CYCLES, then gives a
// one-cycle response. Define MEM_RESP_MISALIGN_CHK_EN to reject addr[1:0] != 0.
module mem_resp
   import mem_pkg::*;
#(
   parameter int DEPTH       = DEPTH_DEF,
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [3:0]        req_be,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_RESP_MISALIGN_CHK_EN
   localparam bit MISALIGN_CHK = 1'b1;
`else
   localparam bit MISALIGN_CHK = 1'b0;
`endif

   state_t            state;
   logic [3:0]        cnt;
   req_t              lat, cur;
   logic              accept, enter_resp, oor, misaligned, err;
   logic [DATA_W-1:0] ram_q;

   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;

   // With zero wait states the RAM access happens on the accept edge itself,
   // so the live request is used in IDLE and the latched copy otherwise.
   always_comb begin
      cur = lat;
      if (state == IDLE) cur = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
   end

   assign enter_resp = (WAIT_CYCLES == 0) ? accept : ((state == WAIT) && (cnt == 4'd0));
   assign oor        = ({2'b00, cur.addr[31:2]} >= 32'(DEPTH));
   assign misaligned = |cur.addr[1:0];
   assign err        = oor || (MISALIGN_CHK && misaligned);

   mem_array #(.DEPTH(DEPTH)) u_array (
      .clk   (clk),
      .en    (enter_resp && !err),
      .we    (cur.we),
      .be    (cur.be),
      .addr  (cur.addr[AW+1:2]),
      .wdata (cur.wdata),
      .rdata (ram_q)
   );

   assign rsp_rdata = (rsp_valid && !rsp_err && !lat.we) ? ram_q : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         lat       <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               lat <= cur;
               if (WAIT_CYCLES == 0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= err;
               end else begin
                  state <= WAIT;
                  cnt   <= 4'(WAIT_CYCLES - 1);
               end
            end
            WAIT: if (cnt == 4'd0) begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= err;
            end else begin
               cnt <= cnt - 4'd1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: directed cases plus random traffic checked
// against a word/byte-level model of the memory and its response rules.
module tb_mem_resp;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  be = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        v0 = 1'b0, we0 = 1'b0;
   logic [31:0] a0 = '0, wd0 = '0;
   logic [3:0]  be0 = '0;
   logic        rdy0, rv0, re0;
   logic [31:0] rd0;

   int errors = 0;
   int checks = 0;
   logic [31:0] mdl [256];
`ifdef MEM_RESP_MISALIGN_CHK_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   always #5 clk = ~clk;

   mem_resp #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req_valid(valid), .req_we(we), .req_addr(addr),
      .req_wdata(wdata), .req_be(be), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

   mem_resp #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(v0), .req_we(we0), .req_addr(a0),
      .req_wdata(wd0), .req_be(be0), .req_ready(rdy0), .rsp_valid(rv0),
      .rsp_rdata(rd0), .rsp_err(re0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
         $error("%s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected outcome straight from the rules: range/alignment decide the error,
   // writes merge enabled bytes, reads return the stored word.
   task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output bit e, output logic [31:0] r);
      int idx;
      idx = int'(a >> 2);
      e = (a >> 2) >= 256 || (MIS && (a % 4) != 0);
      r = '0;
      if (!e) begin
         if (w) begin
            for (int i = 0; i < 4; i++) if (b[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
         end else r = mdl[idx];
      end
   endtask

   task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd, output bit e, output int lat);
      int n;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
      valid = 1'b1; we = w; addr = a; wdata = d; be = b;
      @(posedge clk); #1 valid = 1'b0;
      lat = 0; rd = '0; e = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (rsp_valid) begin lat = k; rd = rsp_rdata; e = rsp_err; break; end
      end
   endtask

   task automatic op(input string tag, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b);
      logic [31:0] rd, xr;
      bit e, xe;
      int lat;
      xact(w, a, d, b, rd, e, lat);
      model(w, a, d, b, xe, xr);
      chk({tag, "_lat"}, 32'(lat), 32'd3);
      chk({tag, "_err"}, 32'(e), 32'(xe));
      if (!w || xe) chk({tag, "_rdata"}, rd, xr);
   endtask

   task automatic wr0(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      v0 = 1'b1; we0 = 1'b1; a0 = a; wd0 = d; be0 = 4'hF;
      @(posedge clk); #1 v0 = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [31:0] w0, w1, rd;
      bit e;
      int lat, n;

      #2;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      chk("rst_ready0", 32'(rdy0), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1 chk("post_rst_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 256; i++) op("fill", 1'b1, 32'(i * 4), $urandom, 4'hF);

      op("full_wr", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      op("full_rd", 1'b0, 32'h10, 32'h0, 4'h0);
      chk("full_rd_lit", mdl[4], 32'hDEADBEEF);
      op("part_wr", 1'b1, 32'h10, 32'h00001234, 4'b0011);
      op("part_rd", 1'b0, 32'h10, 32'h0, 4'h0);
      chk("part_rd_lit", mdl[4], 32'hDEAD1234);
      op("be0_wr", 1'b1, 32'h14, 32'hFFFFFFFF, 4'b0000);
      op("be0_rd", 1'b0, 32'h14, 32'h0, 4'h0);
      op("oor_rd", 1'b0, 32'h400, 32'h0, 4'h0);
      op("oor_wr", 1'b1, 32'h400, 32'hA5A5A5A5, 4'hF);
      op("oor_alias", 1'b0, 32'h0, 32'h0, 4'h0);
      op("mis_rd", 1'b0, 32'h12, 32'h0, 4'h0);

      // Abort a write to 0x20 while it sits in WAIT.
      op("w20_pre", 1'b1, 32'h20, 32'h13572468, 4'hF);
      @(negedge clk);
      valid = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hFFFF0000; be = 4'hF;
      @(posedge clk); #1 valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1 chk("abort_ready_in_rst", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("abort_ready_after", 32'(req_ready), 32'd1);
      n = 0;
      for (int k = 0; k < 5; k++) begin @(negedge clk); if (rsp_valid) n++; end
      chk("abort_no_rsp", 32'(n), 32'd0);
      op("abort_rd20", 1'b0, 32'h20, 32'h0, 4'h0);

      for (int i = 0; i < 150; i++) begin
         op("rand", 1'($urandom), 32'($urandom_range(0, 1100)), $urandom, 4'($urandom));
      end
      for (int i = 0; i < 256; i++) op("scan", 1'b0, 32'(i * 4), 32'h0, 4'h0);

      // Zero wait states: two reads with valid held high.
      w0 = $urandom; w1 = $urandom;
      wr0(32'h0, w0);
      wr0(32'h4, w1);
      @(negedge clk);
      v0 = 1'b1; we0 = 1'b0; a0 = 32'h0;
      @(posedge clk);
      @(negedge clk);
      chk("b2b_c1_valid", 32'(rv0), 32'd1);
      chk("b2b_c1_ready", 32'(rdy0), 32'd0);
      chk("b2b_c1_rdata", rd0, w0);
      a0 = 32'h4;
      @(negedge clk);
      chk("b2b_c2_valid", 32'(rv0), 32'd0);
      chk("b2b_c2_ready", 32'(rdy0), 32'd1);
      @(negedge clk);
      chk("b2b_c3_valid", 32'(rv0), 32'd1);
      chk("b2b_c3_ready", 32'(rdy0), 32'd0);
      chk("b2b_c3_rdata", rd0, w1);
      chk("b2b_c3_err", 32'(re0), 32'd0);
      v0 = 1'b0;
      @(negedge clk);
      chk("b2b_c4_valid", 32'(rv0), 32'd0);

      xact(1'b0, 32'h8, 32'h0, 4'h0, rd, e, lat);
      chk("final_lat", 32'(lat), 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states between accept and response (range 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  write data.
REQ-009 SHALL have port req_be  input  4  byte enables for writes; bit i enables byte i.
REQ-010 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port rsp_rdata  output  32  read data, valid with rsp_valid.
REQ-013 SHALL have port rsp_err  output  1  request rejected, valid with rsp_valid.

Function
REQ-014 SHALL implement states IDLE, WAIT, RESP; encodings fixed in the package.
REQ-015 SHALL drive req_ready=1 only in IDLE with rst low; 0 otherwise.
REQ-016 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1, latching we, addr, wdata and be.
REQ-017 SHALL transition IDLE->WAIT on accept when WAIT_CYCLES>0, and IDLE->RESP when WAIT_CYCLES=0.
REQ-018 SHALL load a wait counter with WAIT_CYCLES-1 on accept, decrement it in WAIT, and go WAIT->RESP on the edge where it is 0.
REQ-019 SHALL spend exactly one cycle in RESP with rsp_valid=1, then return to IDLE.
REQ-020 SHALL give a total latency of WAIT_CYCLES+1 cycles from the accept edge to the rsp_valid cycle.
REQ-021 SHALL commit an accepted write to the array on the edge entering RESP, writing only bytes with req_be set.
REQ-022 SHALL register read data on the edge entering RESP; rsp_rdata=0 outside RESP.
REQ-023 SHALL flag out-of-range when latched addr[31:2] >= DEPTH: rsp_err=1, rsp_rdata=0, array unmodified.
REQ-024 SHALL treat a write with req_be=4'b0000 as a successful no-op (rsp_err=0).
REQ-025 SHALL ignore req_valid outside IDLE; the initiator holds the request until it is accepted.
REQ-026 SHALL allow back-to-back requests: IDLE follows RESP, so accept is possible the cycle after rsp_valid.

Reset
REQ-027 SHALL on rst=1 force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
REQ-028 SHALL abort an in-flight request on reset mid-operation: no write commit and no response.
REQ-029 SHALL NOT clear array contents on reset.

Configuration
REQ-030 SHALL, with MEM_RESP_MISALIGN_CHK_EN defined, reject any request whose latched addr[1:0]!=0 with rsp_err=1, no write, and rsp_rdata=0.
REQ-031 SHALL, without MEM_RESP_MISALIGN_CHK_EN, ignore addr[1:0] and access word addr[31:2].

Structure
REQ-032 SHALL place state encodings, DATA_W=32 and the default DEPTH and WAIT_CYCLES in shared package mem_pkg.
REQ-033 SHALL implement storage in sub-module mem_array: a single-port synchronous RAM with byte-enable write and registered read.

Verification
REQ-034 SHALL cover WAIT_CYCLES=2: write 0xDEADBEEF to addr 0x10 with be=4'hF -> rsp_valid exactly 3 cycles after accept, rsp_err=0; read 0x10 -> rsp_rdata=0xDEADBEEF.
REQ-035 SHALL cover partial write: be=4'b0011, wdata 0x00001234 to addr 0x10 holding 0xDEADBEEF -> read returns 0xDEAD1234.
REQ-036 SHALL cover out of range with DEPTH=256: read addr 0x400 -> rsp_err=1, rsp_rdata=0; write addr 0x400 -> no array word changes.
REQ-037 SHALL cover misalignment: read addr 0x12 with macro defined -> rsp_err=1; without macro -> data of word 0x10, rsp_err=0.
REQ-038 SHALL cover reset mid-operation: assert rst in WAIT during a write to 0x20 -> no rsp_valid, word 0x20 unchanged; req_ready=1 in the first cycle after rst deasserts.
REQ-039 SHALL cover WAIT_CYCLES=0 back-to-back: two reads with req_valid held high -> rsp_valid on cycles 1 and 3, req_ready low while each request is in RESP.
